// File: rtl/writeback_stage.sv
// -----------------------------------------------------------------------------
// writeback_stage
//
// Final pipeline stage. It holds one instruction handed over by the memory
// stage, commits its result through a single register-file write port that can
// apply backpressure, and counts retired instructions. Illegal opcodes,
// ECALL/EBREAK and missing results park the stage in HALTED until clear_halt.
//
// Ports:
//   clk, rst_n               clock (rising edge), asynchronous active-low reset
//   prev_done / stall_prev   upstream valid / this stage refuses transfer
//   *_in                     per-instruction fields from the memory stage
//   reg_write_*              register-file write request, index, data, ready
//   flush                    drop the buffered instruction without retiring it
//   clear_halt               leave HALTED
//   retire_pulse             an instruction retires at this clock edge
//   retire_count             running total of retired instructions
//   halted, halt_cause       HALTED flag and cause (0 none, 1 env, 2 illegal,
//                            3 missing result)
//   halt_pc                  PC of the instruction that caused the halt
// -----------------------------------------------------------------------------
module writeback_stage #(
    parameter int ADDR_WIDTH         = 32,
    parameter int DATA_WIDTH         = 32,
    parameter int NUM_REGISTERS      = 32,
    parameter int RETIRE_COUNT_WIDTH = 64
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          prev_done,
    output logic                          stall_prev,
    input  logic [ADDR_WIDTH-1:0]         program_count_in,
    input  logic                          program_count_valid_in,
    input  logic                          environment_in,
    input  logic                          opcode_legal_in,
    input  logic [4:0]                    write_register_in,
    input  logic                          write_register_valid_in,
    input  logic [DATA_WIDTH-1:0]         result_data_in,
    input  logic                          result_data_valid_in,
    output logic                          reg_write_enable,
    output logic [4:0]                    reg_write_index,
    output logic [DATA_WIDTH-1:0]         reg_write_data,
    input  logic                          reg_write_ready,
    input  logic                          flush,
    input  logic                          clear_halt,
    output logic                          retire_pulse,
    output logic [RETIRE_COUNT_WIDTH-1:0] retire_count,
    output logic                          halted,
    output logic [1:0]                    halt_cause,
    output logic [ADDR_WIDTH-1:0]         halt_pc
);

    localparam int IDX_W = $clog2(NUM_REGISTERS);

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'd0,
        CAUSE_ENV     = 2'd1,
        CAUSE_ILLEGAL = 2'd2,
        CAUSE_MISSING = 2'd3
    } cause_e;

    // The PC-valid qualifier carries no commit decision in this stage.
    logic pc_valid_unused;
    assign pc_valid_unused = program_count_valid_in;

    // State and one-entry instruction buffer.
    state_e                        state_q, state_d;
    logic                          has_input_q, has_input_d;
    logic [ADDR_WIDTH-1:0]         program_count_q, program_count_d;
    logic                          environment_q, environment_d;
    logic                          opcode_legal_q, opcode_legal_d;
    logic [IDX_W-1:0]              write_register_q, write_register_d;
    logic                          write_register_valid_q, write_register_valid_d;
    logic [DATA_WIDTH-1:0]         result_data_q, result_data_d;
    logic                          result_data_valid_q, result_data_valid_d;
    logic [RETIRE_COUNT_WIDTH-1:0] retire_count_q, retire_count_d;
    cause_e                        halt_cause_q, halt_cause_d;
    logic [ADDR_WIDTH-1:0]         halt_pc_q, halt_pc_d;

    logic fault, needs_write, active, fire, fault_take, transfer_prev;

    // Handshake, write port and retire decision.
    always_comb begin
        fault = has_input_q && (!opcode_legal_q || environment_q ||
                                (write_register_valid_q && !result_data_valid_q));
        needs_write = write_register_valid_q && (write_register_q != '0);
        // flush overrides everything: no write and no retire for a flushed entry.
        active      = (state_q == ST_RUN) && has_input_q && !fault && !flush;
        fire        = active && (!needs_write || reg_write_ready);
        fault_take  = (state_q == ST_RUN) && fault && !flush;

        // stall_prev is forced high during reset so nothing is accepted then.
        stall_prev    = !rst_n || (state_q == ST_HALTED) ||
                        (has_input_q && !fire && !flush);
        transfer_prev = prev_done && !stall_prev;

        reg_write_enable = active && needs_write;
        reg_write_index  = reg_write_enable ? 5'(write_register_q) : 5'd0;
        reg_write_data   = reg_write_enable ? result_data_q : '0;
        retire_pulse     = fire;
        halted           = (state_q == ST_HALTED);
        retire_count     = retire_count_q;
        halt_cause       = halt_cause_q;
        halt_pc          = halt_pc_q;
    end

    // Next-state logic.
    // NOTE: every variable gets a default at the top of an always_comb so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d                = state_q;
        has_input_d            = has_input_q;
        program_count_d        = program_count_q;
        environment_d          = environment_q;
        opcode_legal_d         = opcode_legal_q;
        write_register_d       = write_register_q;
        write_register_valid_d = write_register_valid_q;
        result_data_d          = result_data_q;
        result_data_valid_d    = result_data_valid_q;
        retire_count_d         = retire_count_q + {{(RETIRE_COUNT_WIDTH-1){1'b0}}, fire};
        halt_cause_d           = halt_cause_q;
        halt_pc_d              = halt_pc_q;

        case (state_q)
            ST_RUN: begin
                if (fault_take) begin
                    state_d   = ST_HALTED;
                    halt_pc_d = program_count_q;
                    // Priority: illegal opcode, then environment, then missing result.
                    if (!opcode_legal_q)     halt_cause_d = CAUSE_ILLEGAL;
                    else if (environment_q)  halt_cause_d = CAUSE_ENV;
                    else                     halt_cause_d = CAUSE_MISSING;
                end
            end
            ST_HALTED: begin
                if (clear_halt) begin
                    state_d      = ST_RUN;
                    halt_cause_d = CAUSE_NONE;
                end
            end
            default: state_d = ST_RUN;
        endcase

        if (fire || flush || fault_take) has_input_d = 1'b0;

        // A new instruction arriving in the same cycle replaces whatever left.
        if (transfer_prev) begin
            has_input_d            = 1'b1;
            program_count_d        = program_count_in;
            environment_d          = environment_in;
            opcode_legal_d         = opcode_legal_in;
            write_register_d       = write_register_in[IDX_W-1:0];
            write_register_valid_d = write_register_valid_in;
            result_data_d          = result_data_in;
            result_data_valid_d    = result_data_valid_in;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q                <= ST_RUN;
            has_input_q            <= 1'b0;
            program_count_q        <= '0;
            environment_q          <= 1'b0;
            opcode_legal_q         <= 1'b0;
            write_register_q       <= '0;
            write_register_valid_q <= 1'b0;
            result_data_q          <= '0;
            result_data_valid_q    <= 1'b0;
            retire_count_q         <= '0;
            halt_cause_q           <= CAUSE_NONE;
            halt_pc_q              <= '0;
        end else begin
            state_q                <= state_d;
            has_input_q            <= has_input_d;
            program_count_q        <= program_count_d;
            environment_q          <= environment_d;
            opcode_legal_q         <= opcode_legal_d;
            write_register_q       <= write_register_d;
            write_register_valid_q <= write_register_valid_d;
            result_data_q          <= result_data_d;
            result_data_valid_q    <= result_data_valid_d;
            retire_count_q         <= retire_count_d;
            halt_cause_q           <= halt_cause_d;
            halt_pc_q              <= halt_pc_d;
        end
    end

endmodule

// File: tb/tb_writeback_stage.sv
// -----------------------------------------------------------------------------
// tb_writeback_stage
//
// Scoreboard bench for writeback_stage. The driver pushes the expected outcome
// of every accepted instruction (retire with optional write, or halt with
// cause/PC) into a queue; an independent monitor pops and compares whenever
// the DUT retires an instruction or enters HALTED.
// -----------------------------------------------------------------------------
module tb_writeback_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        prev_done;
    logic        stall_prev;
    logic [31:0] program_count_in;
    logic        program_count_valid_in;
    logic        environment_in;
    logic        opcode_legal_in;
    logic [4:0]  write_register_in;
    logic        write_register_valid_in;
    logic [31:0] result_data_in;
    logic        result_data_valid_in;
    logic        reg_write_enable;
    logic [4:0]  reg_write_index;
    logic [31:0] reg_write_data;
    logic        reg_write_ready;
    logic        flush;
    logic        clear_halt;
    logic        retire_pulse;
    logic [63:0] retire_count;
    logic        halted;
    logic [1:0]  halt_cause;
    logic [31:0] halt_pc;

    writeback_stage dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .prev_done               (prev_done),
        .stall_prev              (stall_prev),
        .program_count_in        (program_count_in),
        .program_count_valid_in  (program_count_valid_in),
        .environment_in          (environment_in),
        .opcode_legal_in         (opcode_legal_in),
        .write_register_in       (write_register_in),
        .write_register_valid_in (write_register_valid_in),
        .result_data_in          (result_data_in),
        .result_data_valid_in    (result_data_valid_in),
        .reg_write_enable        (reg_write_enable),
        .reg_write_index         (reg_write_index),
        .reg_write_data          (reg_write_data),
        .reg_write_ready         (reg_write_ready),
        .flush                   (flush),
        .clear_halt              (clear_halt),
        .retire_pulse            (retire_pulse),
        .retire_count            (retire_count),
        .halted                  (halted),
        .halt_cause              (halt_cause),
        .halt_pc                 (halt_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        env;
        logic        legal;
        logic        wv;
        logic [4:0]  idx;
        logic [31:0] data;
        logic        dv;
    } instr_t;

    typedef struct {
        logic        halt;
        logic        wen;
        logic [4:0]  idx;
        logic [31:0] data;
        logic [1:0]  cause;
        logic [31:0] pc;
    } exp_t;

    exp_t        sb[$];
    logic [63:0] exp_count = '0;
    int          checks = 0;
    int          errors = 0;
    logic        halted_prev = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference outcome of one instruction, straight from the stage's rules.
    function automatic exp_t model(input instr_t i);
        exp_t e;
        e.halt = 1'b0; e.wen = 1'b0; e.idx = '0; e.data = '0; e.cause = 2'd0; e.pc = i.pc;
        if (!i.legal)              begin e.halt = 1'b1; e.cause = 2'd2; end
        else if (i.env)            begin e.halt = 1'b1; e.cause = 2'd1; end
        else if (i.wv && !i.dv)    begin e.halt = 1'b1; e.cause = 2'd3; end
        else begin
            e.wen  = i.wv && (i.idx != 5'd0);
            e.idx  = i.idx;
            e.data = i.data;
        end
        return e;
    endfunction

    function automatic instr_t mk(input logic [31:0] pc, input logic [4:0] idx,
                                  input logic [31:0] data, input logic legal,
                                  input logic env, input logic wv, input logic dv);
        instr_t i;
        i.pc = pc; i.idx = idx; i.data = data; i.legal = legal;
        i.env = env; i.wv = wv; i.dv = dv;
        return i;
    endfunction

    function automatic instr_t rand_instr();
        return mk($urandom & 32'hFFFF_FFFC, 5'($urandom), $urandom,
                  $urandom_range(0, 19) != 0, $urandom_range(0, 24) == 0,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 15) != 0);
    endfunction

    // One clock cycle: entered and left at posedge+1.
    task automatic step(input logic pd, input instr_t ins, input logic rdy,
                        input logic fl, input logic clr, output logic stalled);
        logic xfer, drop;
        prev_done               = pd;
        program_count_in        = ins.pc;
        program_count_valid_in  = 1'b1;
        environment_in          = ins.env;
        opcode_legal_in         = ins.legal;
        write_register_in       = ins.idx;
        write_register_valid_in = ins.wv;
        result_data_in          = ins.data;
        result_data_valid_in    = ins.dv;
        reg_write_ready         = rdy;
        flush                   = fl;
        clear_halt              = clr;
        @(negedge clk);
        stalled = stall_prev;
        xfer    = pd && !stall_prev;
        drop    = fl && !halted;
        @(posedge clk);
        if (drop && sb.size() > 0) void'(sb.pop_front());
        if (xfer) sb.push_back(model(ins));
        #1;
    endtask

    task automatic idle(input logic rdy, output logic stalled);
        step(1'b0, mk(32'h0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0), rdy, 1'b0, 1'b0, stalled);
    endtask

    // Monitor: compares DUT activity against the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                halted_prev = 1'b0;
            end else begin
                check("retire_count", retire_count, exp_count);
                if (reg_write_enable) begin
                    if (sb.size() == 0) check("unexpected_write", 64'(sb.size()), 64'd1);
                    else begin
                        check("write_expected", reg_write_enable, sb[0].wen);
                        check("write_index", reg_write_index, sb[0].idx);
                        check("write_data", reg_write_data, sb[0].data);
                    end
                end
                if (retire_pulse) begin
                    if (sb.size() == 0) check("unexpected_retire", 64'(sb.size()), 64'd1);
                    else begin
                        e = sb.pop_front();
                        check("retire_not_halt", e.halt, 1'b0);
                        check("retire_wen", reg_write_enable, e.wen);
                        exp_count++;
                    end
                end
                if (halted && !halted_prev) begin
                    if (sb.size() == 0) check("unexpected_halt", 64'(sb.size()), 64'd1);
                    else begin
                        e = sb.pop_front();
                        check("halt_expected", halted, e.halt);
                        check("halt_cause", halt_cause, e.cause);
                        check("halt_pc", halt_pc, e.pc);
                    end
                end
                if (halted) begin
                    check("halted_stall", stall_prev, 1'b1);
                    check("halted_quiet", {reg_write_enable, retire_pulse}, 2'b00);
                end
                halted_prev = halted;
            end
        end
    end

    initial begin
        logic st;
        rst_n = 1'b0;
        prev_done = 0; program_count_in = 0; program_count_valid_in = 0;
        environment_in = 0; opcode_legal_in = 0; write_register_in = 0;
        write_register_valid_in = 0; result_data_in = 0; result_data_valid_in = 0;
        reg_write_ready = 0; flush = 0; clear_halt = 0;

        // Reset state.
        #12;
        check("rst_stall", stall_prev, 1'b1);
        check("rst_outputs", {reg_write_enable, retire_pulse, halted}, 3'b000);
        check("rst_count", retire_count, 64'd0);
        check("rst_cause", halt_cause, 2'd0);
        check("rst_halt_pc", halt_pc, 32'd0);
        @(negedge clk); #2 rst_n = 1'b1;
        @(posedge clk); #1;

        // Back-to-back writes to x5 and x6.
        step(1, mk(32'h10, 5'd5, 32'h11, 1, 0, 1, 1), 1, 0, 0, st); check("b2b_stall0", st, 1'b0);
        step(1, mk(32'h14, 5'd6, 32'h22, 1, 0, 1, 1), 1, 0, 0, st); check("b2b_stall1", st, 1'b0);
        idle(1, st); check("b2b_stall2", st, 1'b0);
        check("b2b_count", retire_count, 64'd2);

        // Backpressure on x7.
        step(1, mk(32'h18, 5'd7, 32'hDEADBEEF, 1, 0, 1, 1), 0, 0, 0, st);
        for (int k = 0; k < 3; k++) begin idle(0, st); check("bp_stall", st, 1'b1); end
        idle(1, st); check("bp_release", st, 1'b0);
        check("bp_count", retire_count, 64'd3);

        // Write to x0 retires without a write.
        step(1, mk(32'h1C, 5'd0, 32'h1234, 1, 0, 1, 1), 1, 0, 0, st);
        idle(1, st);
        check("x0_count", retire_count, 64'd4);

        // Illegal opcode at 0x100, then clear.
        step(1, mk(32'h100, 5'd3, 32'h5, 0, 0, 1, 1), 1, 0, 0, st);
        idle(1, st);
        check("ill_halted", halted, 1'b1);
        check("ill_cause", halt_cause, 2'd2);
        check("ill_pc", halt_pc, 32'h100);
        check("ill_count", retire_count, 64'd4);
        step(0, mk(0, 0, 0, 1, 0, 0, 0), 1, 0, 1, st);
        check("clr_halted", halted, 1'b0);
        check("clr_cause", halt_cause, 2'd0);
        check("clr_pc_kept", halt_pc, 32'h100);
        step(1, mk(32'h104, 5'd8, 32'h77, 1, 0, 1, 1), 1, 0, 0, st); check("clr_accept", st, 1'b0);
        idle(1, st);
        check("clr_count", retire_count, 64'd5);

        // Environment beats missing result; then missing result alone.
        step(1, mk(32'h200, 5'd4, 32'h1, 1, 1, 1, 0), 1, 0, 0, st);
        idle(1, st); check("env_cause", halt_cause, 2'd1);
        step(0, mk(0, 0, 0, 1, 0, 0, 0), 1, 0, 1, st);
        step(1, mk(32'h300, 5'd4, 32'h1, 1, 0, 1, 0), 1, 0, 0, st);
        idle(1, st); check("miss_cause", halt_cause, 2'd3);
        check("miss_pc", halt_pc, 32'h300);
        step(0, mk(0, 0, 0, 1, 0, 0, 0), 1, 0, 1, st);

        // Flush of a stalled entry, then flush with a same-cycle transfer.
        step(1, mk(32'h400, 5'd10, 32'hAA, 1, 0, 1, 1), 0, 0, 0, st);
        step(0, mk(0, 0, 0, 1, 0, 0, 0), 0, 1, 0, st);
        idle(1, st);
        check("flush_count", retire_count, 64'd5);
        step(1, mk(32'h404, 5'd11, 32'hBB, 1, 0, 1, 1), 0, 0, 0, st);
        step(1, mk(32'h408, 5'd12, 32'hCC, 1, 0, 1, 1), 0, 1, 0, st); check("flush_xfer", st, 1'b0);
        idle(1, st);
        check("flush_xfer_count", retire_count, 64'd6);

        // Randomized traffic.
        for (int n = 0; n < 600; n++) begin
            step($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 19) == 0, halted && ($urandom_range(0, 1) == 1), st);
        end
        for (int n = 0; n < 20 && (sb.size() > 0 || halted); n++)
            step(0, mk(0, 0, 0, 1, 0, 0, 0), 1, 0, halted, st);
        check("drain", 64'(sb.size()), 64'd0);

        // Asynchronous reset while x9 is stalled.
        step(1, mk(32'h500, 5'd9, 32'h99, 1, 0, 1, 1), 0, 0, 0, st);
        idle(0, st);
        #2 rst_n = 1'b0;
        #1;
        check("arst_outputs", {reg_write_enable, retire_pulse, halted}, 3'b000);
        check("arst_index_data", {reg_write_index, reg_write_data}, 37'd0);
        check("arst_count", retire_count, 64'd0);
        check("arst_stall", stall_prev, 1'b1);
        sb.delete();
        exp_count = '0;
        @(negedge clk); #2 rst_n = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) idle(1, st);
        check("arst_no_write", retire_count, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Final pipeline stage. Sits directly downstream of the memory stage and consumes its per-instruction outputs.
- Commits results to the register file through a single write port with backpressure, and counts retired instructions.
- Detects illegal-opcode, environment-call and missing-result conditions and parks the pipeline in a halted state until software or debug clears it.

Parameters:
ADDR_WIDTH, 32, program counter width
DATA_WIDTH, 32, register data width
NUM_REGISTERS, 32, architectural register count; index width = $clog2(NUM_REGISTERS)
RETIRE_COUNT_WIDTH, 64, width of retired-instruction counter

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
prev_done  input  1  upstream has a valid instruction
stall_prev  output  1  this stage refuses transfer this cycle
program_count_in  input  ADDR_WIDTH  instruction PC
program_count_valid_in  input  1  PC valid
environment_in  input  1  ECALL/EBREAK class
opcode_legal_in  input  1  opcode decoded legally
write_register_in  input  5  destination index
write_register_valid_in  input  1  instruction writes a register
result_data_in  input  DATA_WIDTH  value to commit
result_data_valid_in  input  1  result value valid
reg_write_enable  output  1  register-file write request
reg_write_index  output  5  register-file write index
reg_write_data  output  DATA_WIDTH  register-file write data
reg_write_ready  input  1  register file accepts write this cycle
flush  input  1  discard buffered instruction without retiring
clear_halt  input  1  leave HALTED
retire_pulse  output  1  instruction retires at this edge
retire_count  output  RETIRE_COUNT_WIDTH  retired-instruction total
halted  output  1  stage in HALTED state
halt_cause  output  2  0 none, 1 environment, 2 illegal opcode, 3 missing result
halt_pc  output  ADDR_WIDTH  PC of faulting instruction

Behaviour:
Reset (rst_n low, asynchronous):
- has_input=0, state=RUN, retire_count=0, halt_cause=0, halt_pc=0.
- All combinational outputs evaluate to 0. stall_prev=1 while rst_n is low.

Buffer:
- One-entry input register with a has_input flag.
- transfer_prev = prev_done && !stall_prev. On that edge all *_in fields are captured and has_input is set.

FSM states: RUN, HALTED.
- fault = has_input && (!opcode_legal || environment || (write_register_valid && !result_data_valid)).
- needs_write = write_register_valid && write_register != 0.
- In RUN with has_input && !fault && !flush:
  - reg_write_enable = needs_write; index and data are driven from the buffer.
  - fire = !needs_write || reg_write_ready.
  - On a fire edge: retire_pulse=1 (combinational, same cycle) and retire_count increments by 1, wrapping modulo 2^RETIRE_COUNT_WIDTH.
- stall_prev = !rst_n || HALTED || (has_input && !fire && !flush).
- A buffer that retires (or is flushed) in the same cycle that transfer_prev occurs is replaced: has_input stays 1.
- A write to x0 never asserts reg_write_enable but still retires.

Fault (RUN, has_input && fault && !flush):
- No write, no retire.
- Next edge: state=HALTED, has_input=0, halt_pc=buffered PC.
- halt_cause priority: illegal (2) > environment (1) > missing result (3).

HALTED:
- stall_prev=1 and halted=1; no writes.
- clear_halt takes the FSM to RUN at the next edge and clears halt_cause to 0. halt_pc is retained.

flush:
- Highest priority. Forces reg_write_enable=0 and retire_pulse=0, and clears has_input at the next edge unless transfer_prev also occurs. A transfer in the same cycle wins.
- flush in HALTED has no effect on state.
- flush and fault in the same cycle: no halt.

Latency:
- Instruction captured at edge N drives the write port in cycle N+1.
- Earliest retire is edge N+1, giving sustained throughput of 1 per cycle.

Reset asserted mid-stall drops the buffered instruction without writing.

Test Plan:
- Back-to-back ADDs writing x5=0x11, x6=0x22, reg_write_ready=1 -> writes in consecutive cycles, retire_count 0->1->2, stall_prev never high.
- reg_write_ready=0 for 3 cycles with x7=0xDEADBEEF buffered -> reg_write_enable held with stable index/data, stall_prev=1 for 3 cycles, single retire_pulse when ready rises.
- write_register=x0, result 0x1234 -> reg_write_enable=0, retire_pulse=1, count increments.
- opcode_legal_in=0 at PC 0x100 -> next edge halted=1, halt_cause=2, halt_pc=0x100, no retire. Hold clear_halt for 1 cycle -> RUN, halt_cause=0, next instruction accepted.
- environment=1 and write_register_valid=1 with result_data_valid=0 -> halt_cause=1 (priority). Separate case with missing result only -> halt_cause=3.
- Assert rst_n low asynchronously mid-stall with x9 pending -> outputs 0 immediately, retire_count=0, no write after release.
